// File: rtl/m_p2s_stream.sv
// Parallel-to-serial transmitter: WORD-bit words in over valid/ready, one bit every CLKS_PER_BIT clocks out.
// Optional macro P2S_PARITY_EN appends an even-parity bit after the data bits of each frame.
module m_p2s_stream #(
    parameter int WORD         = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WORD-1:0] data_in,
    input  logic            lsb_first,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            ser_o,
    output logic            ser_valid,
    output logic            frame_start,
    output logic            frame_done,
    output logic            busy
);
    localparam int BW = $clog2(WORD + 1);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t            state, state_n;
    logic [WORD-1:0]   shreg, shreg_n;
    logic              dir, dir_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [CW-1:0]     clk_cnt, clk_cnt_n;
    logic [WORD-1:0]   buf_data, buf_data_n;
    logic              buf_lsb, buf_lsb_n;
    logic              buf_full, buf_full_n;
    logic              ser_o_n, ser_valid_n;
`ifdef P2S_PARITY_EN
    logic              par, par_n;
`endif

    logic              bit_end, last_data, accept, frame_end, load;
    logic [WORD-1:0]   load_data;
    logic              load_lsb;

    // Handshake: a word moves on a rising edge with in_valid && in_ready;
    // in_ready depends only on the holding buffer, never on in_valid.
    assign in_ready = !buf_full;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE) || buf_full;

    assign bit_end   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_data = (bit_cnt == BW'(WORD - 1));
`ifdef P2S_PARITY_EN
    assign frame_end = (state == PARITY) && bit_end;
`else
    assign frame_end = (state == SHIFT) && last_data && bit_end;
`endif
    assign frame_done  = frame_end;
    assign frame_start = (state == SHIFT) && (bit_cnt == BW'(0)) && (clk_cnt == CW'(0));

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        dir_n       = dir;
        bit_cnt_n   = bit_cnt;
        clk_cnt_n   = clk_cnt;
        buf_data_n  = buf_data;
        buf_lsb_n   = buf_lsb;
        buf_full_n  = buf_full;
        ser_o_n     = ser_o;
        ser_valid_n = ser_valid;
`ifdef P2S_PARITY_EN
        par_n       = par;
`endif
        load      = 1'b0;
        load_data = data_in;
        load_lsb  = lsb_first;

        case (state)
            IDLE: begin
                if (accept) load = 1'b1;
            end
            SHIFT: begin
                if (!bit_end) begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end else begin
                    clk_cnt_n = CW'(0);
                    if (!last_data) begin
                        bit_cnt_n = bit_cnt + BW'(1);
                        ser_o_n   = dir ? shreg[0] : shreg[WORD-1];
                        shreg_n   = dir ? (shreg >> 1) : (shreg << 1);
                    end
`ifdef P2S_PARITY_EN
                    else begin
                        state_n = PARITY;
                        ser_o_n = par;
                    end
`endif
                end
            end
            default: begin
                clk_cnt_n = bit_end ? CW'(0) : clk_cnt + CW'(1);
            end
        endcase

        // At a frame boundary the buffered word wins; otherwise a word offered
        // on that same edge goes straight into the shifter with no gap.
        if (frame_end) begin
            if (buf_full) begin
                load       = 1'b1;
                load_data  = buf_data;
                load_lsb   = buf_lsb;
                buf_full_n = 1'b0;
            end else if (accept) begin
                load = 1'b1;
            end else begin
                state_n     = IDLE;
                ser_valid_n = 1'b0;
                ser_o_n     = 1'b0;
                bit_cnt_n   = BW'(0);
                clk_cnt_n   = CW'(0);
            end
        end else if ((state != IDLE) && accept) begin
            buf_data_n = data_in;
            buf_lsb_n  = lsb_first;
            buf_full_n = 1'b1;
        end

        if (load) begin
            state_n     = SHIFT;
            dir_n       = load_lsb;
            ser_o_n     = load_lsb ? load_data[0] : load_data[WORD-1];
            shreg_n     = load_lsb ? (load_data >> 1) : (load_data << 1);
            bit_cnt_n   = BW'(0);
            clk_cnt_n   = CW'(0);
            ser_valid_n = 1'b1;
`ifdef P2S_PARITY_EN
            par_n       = ^load_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            dir       <= 1'b0;
            bit_cnt   <= '0;
            clk_cnt   <= '0;
            buf_data  <= '0;
            buf_lsb   <= 1'b0;
            buf_full  <= 1'b0;
            ser_o     <= 1'b0;
            ser_valid <= 1'b0;
`ifdef P2S_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            dir       <= dir_n;
            bit_cnt   <= bit_cnt_n;
            clk_cnt   <= clk_cnt_n;
            buf_data  <= buf_data_n;
            buf_lsb   <= buf_lsb_n;
            buf_full  <= buf_full_n;
            ser_o     <= ser_o_n;
            ser_valid <= ser_valid_n;
`ifdef P2S_PARITY_EN
            par       <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_m_p2s_stream.sv
// Directed bench for m_p2s_stream: one instance at 1 clock/bit, one at 3 clocks/bit.
module tb_m_p2s_stream;
`ifdef P2S_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 8 + PAR;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic lsb_first = 1'b0;
    logic in_valid1 = 1'b0, in_valid3 = 1'b0;
    logic sel = 1'b0;
    logic rdy1, ser1, sv1, fs1, fd1, busy1;
    logic rdy3, ser3, sv3, fs3, fd3, busy3;
    logic o_rdy, o_ser, o_sv, o_fs, o_fd, o_busy;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    m_p2s_stream #(.WORD(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset(reset), .data_in(data_in), .lsb_first(lsb_first),
        .in_valid(in_valid1), .in_ready(rdy1), .ser_o(ser1), .ser_valid(sv1),
        .frame_start(fs1), .frame_done(fd1), .busy(busy1));

    m_p2s_stream #(.WORD(8), .CLKS_PER_BIT(3)) dut3 (
        .clk(clk), .reset(reset), .data_in(data_in), .lsb_first(lsb_first),
        .in_valid(in_valid3), .in_ready(rdy3), .ser_o(ser3), .ser_valid(sv3),
        .frame_start(fs3), .frame_done(fd3), .busy(busy3));

    assign o_rdy  = sel ? rdy3  : rdy1;
    assign o_ser  = sel ? ser3  : ser1;
    assign o_sv   = sel ? sv3   : sv1;
    assign o_fs   = sel ? fs3   : fs1;
    assign o_fd   = sel ? fd3   : fd1;
    assign o_busy = sel ? busy3 : busy1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected serial bit b of word w (b == 8 is the even-parity bit).
    function automatic logic exp_bit(input logic [7:0] w, input logic lsb, input int b);
        if (b >= 8) return ^w;
        return lsb ? w[b] : w[7-b];
    endfunction

    task automatic send(input logic [7:0] w, input logic lsb, input logic use3);
        data_in   = w;
        lsb_first = lsb;
        sel       = use3;
        if (use3) in_valid3 = 1'b1; else in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        in_valid3 = 1'b0;
    endtask

    // Checks a whole frame starting at the current sample point, then the idle state after it.
    task automatic run_frame(input logic [7:0] w, input logic lsb, input int cpb, input string tag);
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < cpb; c++) begin
                chk({tag, "_ser"},  {31'd0, o_ser}, {31'd0, exp_bit(w, lsb, b)});
                chk({tag, "_sv"},   {31'd0, o_sv}, 32'd1);
                chk({tag, "_fs"},   {31'd0, o_fs}, {31'd0, (b == 0 && c == 0)});
                chk({tag, "_fd"},   {31'd0, o_fd}, {31'd0, (b == NB-1 && c == cpb-1)});
                chk({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
                tick();
            end
        end
        chk({tag, "_end_sv"},   {31'd0, o_sv}, 32'd0);
        chk({tag, "_end_ser"},  {31'd0, o_ser}, 32'd0);
        chk({tag, "_end_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_end_rdy"},  {31'd0, o_rdy}, 32'd1);
    endtask

    initial begin
        logic [15:0] pair;
        logic [7:0] fw;
        int f, b;

        // Reset state
        tick();
        tick();
        chk("rst_ser",  {31'd0, ser1}, 32'd0);
        chk("rst_sv",   {31'd0, sv1}, 32'd0);
        chk("rst_fs",   {31'd0, fs1}, 32'd0);
        chk("rst_fd",   {31'd0, fd1}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_busy3", {31'd0, busy3}, 32'd0);
        #2 reset = 1'b1;
        tick();
        chk("post_rst_rdy", {31'd0, rdy1}, 32'd1);

        // Single frames, both bit orders and a few patterns
        send(8'h0F, 1'b0, 1'b0); run_frame(8'h0F, 1'b0, 1, "msb_0f");
        send(8'h0F, 1'b1, 1'b0); run_frame(8'h0F, 1'b1, 1, "lsb_0f");
        send(8'hA5, 1'b1, 1'b0); run_frame(8'hA5, 1'b1, 1, "lsb_a5");
        send(8'h07, 1'b0, 1'b0); run_frame(8'h07, 1'b0, 1, "msb_07");
        send(8'h03, 1'b0, 1'b0); run_frame(8'h03, 1'b0, 1, "msb_03");

        // Slow bit period
        send(8'hA5, 1'b0, 1'b1); run_frame(8'hA5, 1'b0, 3, "cpb3_a5");
        sel = 1'b0;

        // Back-to-back: 0x0F then 0xF0 with no gap
        pair = 16'h0FF0;
        data_in = 8'h0F; lsb_first = 1'b0; in_valid1 = 1'b1;
        tick();
        for (int i = 0; i < 2*NB; i++) begin
            f  = i / NB;
            b  = i % NB;
            fw = f ? pair[7:0] : pair[15:8];
            chk("b2b_ser", {31'd0, ser1}, {31'd0, exp_bit(fw, 1'b0, b)});
            chk("b2b_sv",  {31'd0, sv1}, 32'd1);
            chk("b2b_fs",  {31'd0, fs1}, {31'd0, (b == 0)});
            chk("b2b_fd",  {31'd0, fd1}, {31'd0, (b == NB-1)});
            chk("b2b_rdy", {31'd0, rdy1}, {31'd0, !(i >= 1 && i < NB)});
            if (i == 0) data_in = 8'hF0;
            if (i == 1) in_valid1 = 1'b0;
            tick();
        end
        chk("b2b_end_sv",   {31'd0, sv1}, 32'd0);
        chk("b2b_end_busy", {31'd0, busy1}, 32'd0);

        // Zero word is transmitted; reset asserted at bit 4 aborts the frame
        send(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("zero_ser", {31'd0, ser1}, 32'd0);
            chk("zero_sv",  {31'd0, sv1}, 32'd1);
            chk("zero_fs",  {31'd0, fs1}, {31'd0, (i == 0)});
            tick();
        end
        reset = 1'b0;
        #1;
        chk("abort_sv",   {31'd0, sv1}, 32'd0);
        chk("abort_ser",  {31'd0, ser1}, 32'd0);
        chk("abort_fd",   {31'd0, fd1}, 32'd0);
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        tick();
        #2 reset = 1'b1;
        tick();
        chk("abort_rdy", {31'd0, rdy1}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("abort_no_fd", {31'd0, fd1}, 32'd0);
            chk("abort_no_sv", {31'd0, sv1}, 32'd0);
            tick();
        end

        // Transmitter still works after the abort
        send(8'h3C, 1'b1, 1'b0); run_frame(8'h3C, 1'b1, 1, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/m_p2s_stream.md
Name: m_p2s_stream

Overview:
Parametrised parallel-to-serial transmitter.
- Accepts WORD-bit words over a valid/ready handshake and shifts each out one bit at a time, MSB-first or LSB-first per word.
- Bit period is programmable in clocks.
- A one-entry holding buffer allows back-to-back frames with no idle gap.
- Sits between the MPU datapath and serial link/pin drivers; supersedes the fixed 8-bit start-gated serializer.

Parameters:
WORD, 8, data word width in bits (>=2)
CLKS_PER_BIT, 1, clock cycles each serial bit is held on ser_o (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  WORD  parallel word to transmit
lsb_first  input  1  per-word order select, sampled with data_in on handshake (0 = MSB first)
in_valid  input  1  data_in/lsb_first valid
in_ready  output  1  block can accept a word this cycle
ser_o  output  1  serial data, registered
ser_valid  output  1  high while ser_o carries a frame bit, registered
frame_start  output  1  one-cycle pulse, first cycle of each frame
frame_done  output  1  one-cycle pulse, last cycle of each frame
busy  output  1  frame in progress or holding buffer full

Behaviour:
- Reset: clk and reset as decided (reset asynchronous, active-low; clock clk). While reset is low, all registers clear: ser_o=0, ser_valid=0, frame_start=0, frame_done=0, busy=0, holding buffer empty, counters 0. in_ready=1 from the first edge after release.
- Handshake: word accepted on a rising edge where in_valid && in_ready. in_ready = !buffer_full; it is combinational from state and independent of in_valid. data_in is not required to be held after acceptance.
- States: IDLE and SHIFT; PARITY is added under the macro.
- IDLE: an accepted word bypasses the buffer and loads the shift register directly. On the same edge: first bit drives ser_o, ser_valid=1, frame_start=1, state -> SHIFT. Latency from accepting edge to first bit = 0 cycles; bit visible in the following cycle.
- SHIFT:
  - Bit timer counts 0..CLKS_PER_BIT-1; each bit is held exactly CLKS_PER_BIT cycles.
  - Bit counter 0..WORD-1, width $clog2(WORD+1).
  - Shift direction: left (MSB out) when lsb_first=0, right (LSB out) when lsb_first=1.
- Words accepted during SHIFT go to the holding buffer; in_ready then drops to 0.
- Frame end: frame_done is high during the final clock of the last bit period.
  - If the buffer is full, the next edge loads the buffered word, pulses frame_start and keeps ser_valid=1 (zero gap). The buffer empties and in_ready returns to 1 on that edge.
  - If the buffer is empty and in_valid && in_ready on that same edge, the word loads directly (zero gap).
  - Otherwise: state -> IDLE, ser_valid=0, ser_o=0.
- A word value of 0 is a legal word and is transmitted; no value is ignored.
- busy = (state != IDLE) || buffer_full.
- Reset asserted mid-frame aborts immediately: ser_valid=0, ser_o=0, no frame_done, buffered word discarded.
- in_valid held high continuously produces a continuous bit stream; frame_start and frame_done may be high in adjacent cycles only at frame boundaries.

Optional Feature:
- Macro P2S_PARITY_EN.
- Defined: after the WORD data bits, state PARITY appends one even-parity bit (XOR of all data bits) for CLKS_PER_BIT cycles, with ser_valid=1. Frame length is WORD+1 bits. frame_done moves to the parity bit's last cycle.
- Undefined: no PARITY state; frame length is WORD bits.

Test Plan:
- WORD=8, CLKS_PER_BIT=1, lsb_first=0, send 0x0F -> ser_o 0,0,0,0,1,1,1,1 on 8 consecutive cycles; ser_valid high for exactly 8 cycles; frame_start on cycle 1, frame_done on cycle 8; then busy=0, ser_o=0.
- Same with lsb_first=1, send 0x0F -> ser_o 1,1,1,1,0,0,0,0.
- in_valid held high with 0x0F then 0xF0 (MSB first) -> 16 contiguous ser_valid cycles, bits 00001111 11110000; in_ready low from the second accept until the first frame's frame_done edge; frame_start pulses on cycles 1 and 9.
- CLKS_PER_BIT=3, send 0xA5 MSB first -> each bit held 3 cycles; 24 ser_valid cycles; frame_done on cycle 24 only.
- Send 0x00 -> 8 zero bits with ser_valid=1 (not skipped). Assert reset low at bit 4 -> outputs 0 at once; after release, in_ready=1 and no frame_done is emitted.
- P2S_PARITY_EN defined, send 0x07 -> 9 ser_valid cycles, 9th bit = 1; send 0x03 -> 9th bit = 0.
